// File: rtl/data_memory_dbg.sv
// data_memory_dbg: byte-addressed data memory, sub-word core port, priority debug port, 1-cycle registered responses
module data_memory_dbg #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [1:0]        core_size_i,
  input  logic              core_unsigned_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_err_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o
);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0] c_idx, d_idx;
  logic c_err, d_oor, c_wr, d_wr;
  logic [3:0] c_be;
  logic [DATA_W-1:0] c_wd, c_word, c_sh, c_ld;
  always_comb begin
    c_idx = core_addr_i[IW+1:2];
    d_idx = dbg_addr_i[IW+1:2];
    d_oor = |dbg_addr_i[ADDR_W-1:IW+2];
    c_err = (|core_addr_i[ADDR_W-1:IW+2]) | (core_size_i == 2'b11)
          | ((core_size_i == 2'b01) & core_addr_i[0])
          | ((core_size_i == 2'b10) & (|core_addr_i[1:0]));
    c_be = core_size_i == 2'b00 ? 4'b0001 << core_addr_i[1:0] :
           core_size_i == 2'b01 ? (core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    c_wd = core_size_i == 2'b00 ? {4{core_wdata_i[7:0]}} :
           core_size_i == 2'b01 ? {2{core_wdata_i[15:0]}} : core_wdata_i;
    c_word = mem[c_idx];
    c_sh = c_word >> {core_addr_i[1:0], 3'b000};
    c_ld = core_size_i == 2'b00 ? {{24{~core_unsigned_i & c_sh[7]}}, c_sh[7:0]} :
           core_size_i == 2'b01 ? {{16{~core_unsigned_i & c_sh[15]}}, c_sh[15:0]} : c_word;
    dbg_gnt_o = dbg_req_i & rst_ni;
    core_gnt_o = core_req_i & ~dbg_req_i & rst_ni;
    d_wr = dbg_gnt_o & dbg_we_i & ~d_oor;
    c_wr = core_gnt_o & core_we_i & ~c_err;
  end
  always_ff @(posedge clk_i) begin
    if (d_wr) mem[d_idx] <= dbg_wdata_i;
    else if (c_wr)
      for (int i = 0; i < 4; i++)
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wd[8*i +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_rvalid_o <= 1'b0;
      core_err_o    <= 1'b0;
      core_rdata_o  <= '0;
      dbg_rvalid_o  <= 1'b0;
      dbg_rdata_o   <= '0;
    end else begin
      core_rvalid_o <= core_gnt_o;
      core_err_o    <= core_gnt_o & c_err;
      if (core_gnt_o) core_rdata_o <= (core_we_i | c_err) ? '0 : c_ld;
      dbg_rvalid_o <= dbg_gnt_o;
      if (dbg_gnt_o) dbg_rdata_o <= (dbg_we_i | d_oor) ? '0 : mem[d_idx];
    end
  end
endmodule

// File: tb/tb_data_memory_dbg.sv
// tb_data_memory_dbg: byte-array reference model with directed and random core/debug traffic
module tb_data_memory_dbg;
  localparam int DEPTH = 64;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic core_req_i = 0, core_we_i = 0, core_unsigned_i = 0;
  logic [1:0] core_size_i = 0;
  logic [31:0] core_addr_i = 0, core_wdata_i = 0;
  logic core_gnt_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic dbg_req_i = 0, dbg_we_i = 0;
  logic [31:0] dbg_addr_i = 0, dbg_wdata_i = 0;
  logic dbg_gnt_o, dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic [7:0] rmem [4*DEPTH];
  int total = 0, bad = 0;
  data_memory_dbg #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_unsigned_i(core_unsigned_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit oor(input logic [31:0] a);
    return a >= 32'(4*DEPTH);
  endfunction
  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || oor(a);
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int n = 1 << sz;
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | ({24'b0, rmem[int'(a) + i]} << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction
  task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) rmem[int'(a) + i] = wd[8*i +: 8];
  endtask
  task automatic core_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    bit e;
    logic [31:0] exp;
    e = model_err(a, sz);
    exp = (we || e) ? 32'h0 : model_load(a, sz, uns);
    if (we && !e) model_store(a, 1 << sz, wd);
    core_req_i = 1; core_we_i = we; core_size_i = sz; core_unsigned_i = uns;
    core_addr_i = a; core_wdata_i = wd;
    #1 chk("core_gnt", {31'b0, core_gnt_o}, 1);
    @(posedge clk_i); #1;
    core_req_i = 0;
    chk("core_rvalid", {31'b0, core_rvalid_o}, 1);
    chk("core_err", {31'b0, core_err_o}, {31'b0, e});
    chk("core_rdata", core_rdata_o, exp);
  endtask
  task automatic dbg_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    exp = (we || oor(a)) ? 32'h0 : model_load(a & ~32'h3, 2'd2, 1'b0);
    if (we && !oor(a)) model_store(a & ~32'h3, 4, wd);
    dbg_req_i = 1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = wd;
    #1 chk("dbg_gnt", {31'b0, dbg_gnt_o}, 1);
    @(posedge clk_i); #1;
    dbg_req_i = 0;
    chk("dbg_rvalid", {31'b0, dbg_rvalid_o}, 1);
    chk("dbg_rdata", dbg_rdata_o, exp);
  endtask
  initial begin
    logic [31:0] a;
    core_req_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_core_gnt", {31'b0, core_gnt_o}, 0);
    chk("rst_core_rvalid", {31'b0, core_rvalid_o}, 0);
    chk("rst_core_err", {31'b0, core_err_o}, 0);
    chk("rst_core_rdata", core_rdata_o, 0);
    chk("rst_dbg_rvalid", {31'b0, dbg_rvalid_o}, 0);
    chk("rst_dbg_rdata", dbg_rdata_o, 0);
    core_req_i = 0;
    rst_ni = 1;
    @(posedge clk_i); #1;
    for (int w = 0; w < DEPTH; w++) dbg_op(1, 32'(w*4), $urandom);
    core_op(1, 2, 0, 32'h30, 32'hDEAD_BEEF);
    core_op(0, 2, 0, 32'h30, 0);
    chk("lw_deadbeef", core_rdata_o, 32'hDEAD_BEEF);
    core_op(1, 0, 0, 32'h31, 32'h80);
    core_op(0, 0, 0, 32'h31, 0);
    chk("lb_80", core_rdata_o, 32'hFFFF_FF80);
    core_op(0, 0, 1, 32'h31, 0);
    chk("lbu_80", core_rdata_o, 32'h0000_0080);
    core_op(0, 2, 0, 32'h30, 0);
    chk("lw_after_sb", core_rdata_o, 32'hDEAD_80EF);
    @(posedge clk_i); #1;
    chk("hold_rvalid", {31'b0, core_rvalid_o}, 0);
    chk("hold_rdata", core_rdata_o, 32'hDEAD_80EF);
    core_op(1, 1, 0, 32'h22, 32'h1234);
    core_op(0, 1, 0, 32'h22, 0);
    chk("lh_1234", core_rdata_o, 32'h0000_1234);
    core_op(1, 1, 0, 32'h23, 32'hFFFF);
    core_op(0, 1, 0, 32'h23, 0);
    core_op(0, 2, 0, 32'h20, 0);
    core_op(1, 3, 0, 32'h10, 32'h1);
    core_op(0, 2, 0, 32'h10, 0);
    core_req_i = 1; core_we_i = 0; core_size_i = 2; core_unsigned_i = 0; core_addr_i = 32'h30;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 32'h30; dbg_wdata_i = 32'h55;
    #1;
    chk("arb_dbg_gnt", {31'b0, dbg_gnt_o}, 1);
    chk("arb_core_gnt", {31'b0, core_gnt_o}, 0);
    @(posedge clk_i); #1;
    dbg_req_i = 0;
    model_store(32'h30, 4, 32'h55);
    chk("arb_dbg_rvalid", {31'b0, dbg_rvalid_o}, 1);
    chk("arb_core_rvalid", {31'b0, core_rvalid_o}, 0);
    #1 chk("arb_core_gnt2", {31'b0, core_gnt_o}, 1);
    @(posedge clk_i); #1;
    core_req_i = 0;
    chk("arb_core_rvalid2", {31'b0, core_rvalid_o}, 1);
    chk("arb_core_rdata", core_rdata_o, 32'h0000_0055);
    core_req_i = 1; core_we_i = 1; core_size_i = 2; core_addr_i = 32'h30; core_wdata_i = 32'hA5A5_0001;
    dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 32'h30; dbg_wdata_i = 32'h1111_2222;
    @(posedge clk_i); #1;
    dbg_req_i = 0;
    #1 chk("simw_core_gnt", {31'b0, core_gnt_o}, 1);
    @(posedge clk_i); #1;
    core_req_i = 0;
    model_store(32'h30, 4, 32'hA5A5_0001);
    core_op(0, 2, 0, 32'h30, 0);
    chk("simw_final", core_rdata_o, 32'hA5A5_0001);
    core_op(1, 2, 0, 32'(4*DEPTH), 32'hCAFE_F00D);
    core_op(0, 0, 0, 32'(4*DEPTH), 0);
    core_op(0, 2, 0, 32'h0, 0);
    dbg_op(0, 32'(4*DEPTH), 0);
    dbg_op(1, 32'(4*DEPTH), 32'h1234_5678);
    dbg_op(0, 32'h0, 0);
    core_req_i = 1; core_we_i = 0; core_size_i = 2; core_addr_i = 32'h30;
    @(posedge clk_i); #1;
    core_req_i = 0;
    rst_ni = 0;
    #1;
    chk("midrst_rvalid", {31'b0, core_rvalid_o}, 0);
    chk("midrst_rdata", core_rdata_o, 0);
    chk("midrst_err", {31'b0, core_err_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(posedge clk_i); #1;
    chk("postrst_rvalid", {31'b0, core_rvalid_o}, 0);
    chk("postrst_rdata", core_rdata_o, 0);
    chk("postrst_dbg_rvalid", {31'b0, dbg_rvalid_o}, 0);
    core_op(0, 2, 0, 32'h30, 0);
    for (int k = 0; k < 400; k++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'(4*DEPTH) + $urandom_range(0, 1023) :
          ($urandom_range(0, 19) == 0) ? (32'h8000_0000 | $urandom_range(0, 4*DEPTH-1)) :
          32'($urandom_range(0, 4*DEPTH-1));
      if ($urandom_range(0, 3) == 0) dbg_op(1'($urandom_range(0, 1)), a, $urandom);
      else core_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
